// File: rtl/alu_lockstep_n_if.sv
// Bus bundle for alu_lockstep_n: operand/opcode inputs, lane results and error reporting.
// Inject ports exist only when ALU_LOCKSTEP_INJECT_EN is defined.
interface alu_lockstep_n_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             lockstep;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic [2:0]       sel0, sel1;
    logic             clr_i;
`ifdef ALU_LOCKSTEP_INJECT_EN
    logic             inj_en;
    logic [WIDTH-1:0] inj_mask;
`endif
    logic             out_valid;
    logic [WIDTH-1:0] alu_out0, alu_out1;
    logic             carry0, carry1;
    logic [WIDTH-1:0] x;
    logic             y;
    logic             mism;
    logic [CNT_W-1:0] err_cnt;
    logic             err_sticky;
    logic             irq;

    modport master (
`ifdef ALU_LOCKSTEP_INJECT_EN
        output inj_en, inj_mask,
`endif
        output in_valid, lockstep, a0, b0, a1, b1, sel0, sel1, clr_i,
        input  out_valid, alu_out0, alu_out1, carry0, carry1, x, y, mism,
        input  err_cnt, err_sticky, irq
    );

    modport slave (
`ifdef ALU_LOCKSTEP_INJECT_EN
        input  inj_en, inj_mask,
`endif
        input  in_valid, lockstep, a0, b0, a1, b1, sel0, sel1, clr_i,
        output out_valid, alu_out0, alu_out1, carry0, carry1, x, y, mism,
        output err_cnt, err_sticky, irq
    );
endinterface

// File: rtl/alu_lockstep_n.sv
// Two-stage dual-lane ALU with lockstep comparator, saturating error counter, sticky flag and irq.
// Optional lane-2 fault injection is enabled by defining ALU_LOCKSTEP_INJECT_EN.
module alu_lockstep_n #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n,
    alu_lockstep_n_if.slave   bus
);
    logic             v1_q, v1_d;
    logic [WIDTH-1:0] a0_q, a0_d, b0_q, b0_d, a1_q, a1_d, b1_q, b1_d;
    logic [2:0]       s0_q, s0_d, s1_q, s1_d;
`ifdef ALU_LOCKSTEP_INJECT_EN
    logic             inj_q, inj_d;
    logic [WIDTH-1:0] mask_q, mask_d;
`endif
    logic             v2_q, v2_d;
    logic [WIDTH-1:0] out0_q, out0_d, out1_q, out1_d, x_q, x_d;
    logic             c0_q, c0_d, c1_q, c1_d, y_q, y_d, mism_q, mism_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sticky_q, sticky_d, irq_q, irq_d;
    logic [WIDTH:0]   r0, r1;
    logic [WIDTH-1:0] res1;

    function automatic logic [WIDTH:0] alu_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [2:0]       op);
        logic [WIDTH:0] r;
        case (op)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, a ^ b};
            3'b101:  r = {1'b0, ~(a & b)};
            3'b110:  r = {1'b0, a};
            default: r = {1'b0, b};
        endcase
        return r;
    endfunction

    // Lockstep steering happens at capture, so stage 1 always holds lane 2's effective operands.
    always_comb begin
        v1_d = bus.in_valid;
        a0_d = a0_q; b0_d = b0_q; s0_d = s0_q;
        a1_d = a1_q; b1_d = b1_q; s1_d = s1_q;
`ifdef ALU_LOCKSTEP_INJECT_EN
        inj_d  = inj_q;
        mask_d = mask_q;
`endif
        if (bus.in_valid) begin
            a0_d = bus.a0; b0_d = bus.b0; s0_d = bus.sel0;
            a1_d = bus.lockstep ? bus.a0   : bus.a1;
            b1_d = bus.lockstep ? bus.b0   : bus.b1;
            s1_d = bus.lockstep ? bus.sel0 : bus.sel1;
`ifdef ALU_LOCKSTEP_INJECT_EN
            inj_d  = bus.inj_en;
            mask_d = bus.inj_mask;
`endif
        end
    end

    always_comb begin
        r0 = alu_op(a0_q, b0_q, s0_q);
        r1 = alu_op(a1_q, b1_q, s1_q);
`ifdef ALU_LOCKSTEP_INJECT_EN
        res1 = r1[WIDTH-1:0] ^ (inj_q ? mask_q : '0);
`else
        res1 = r1[WIDTH-1:0];
`endif
        v2_d   = v1_q;
        out0_d = out0_q; c0_d = c0_q;
        out1_d = out1_q; c1_d = c1_q;
        x_d    = '0;
        y_d    = 1'b0;
        mism_d = 1'b0;
        if (v1_q) begin
            out0_d = r0[WIDTH-1:0]; c0_d = r0[WIDTH];
            out1_d = res1;          c1_d = r1[WIDTH];
            x_d    = r0[WIDTH-1:0] ^ res1;
            y_d    = r0[WIDTH] ^ r1[WIDTH];
            mism_d = (|x_d) | y_d;
        end
    end

    // A recorded mismatch beats a simultaneous clear: count restarts at 1 and irq pulses.
    always_comb begin
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        irq_d    = 1'b0;
        if (v2_q && mism_q) begin
            sticky_d = 1'b1;
            irq_d    = ~sticky_q | bus.clr_i;
            if (bus.clr_i)   cnt_d = CNT_W'(1);
            else if (~&cnt_q) cnt_d = cnt_q + CNT_W'(1);
        end else if (bus.clr_i) begin
            cnt_d    = '0;
            sticky_d = 1'b0;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            v1_q <= 1'b0;
            a0_q <= '0; b0_q <= '0; s0_q <= '0;
            a1_q <= '0; b1_q <= '0; s1_q <= '0;
`ifdef ALU_LOCKSTEP_INJECT_EN
            inj_q  <= 1'b0;
            mask_q <= '0;
`endif
            v2_q   <= 1'b0;
            out0_q <= '0; c0_q <= 1'b0;
            out1_q <= '0; c1_q <= 1'b0;
            x_q    <= '0; y_q <= 1'b0; mism_q <= 1'b0;
            cnt_q  <= '0; sticky_q <= 1'b0; irq_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            a0_q <= a0_d; b0_q <= b0_d; s0_q <= s0_d;
            a1_q <= a1_d; b1_q <= b1_d; s1_q <= s1_d;
`ifdef ALU_LOCKSTEP_INJECT_EN
            inj_q  <= inj_d;
            mask_q <= mask_d;
`endif
            v2_q   <= v2_d;
            out0_q <= out0_d; c0_q <= c0_d;
            out1_q <= out1_d; c1_q <= c1_d;
            x_q    <= x_d; y_q <= y_d; mism_q <= mism_d;
            cnt_q  <= cnt_d; sticky_q <= sticky_d; irq_q <= irq_d;
        end
    end

    assign bus.out_valid  = v2_q;
    assign bus.alu_out0   = out0_q;
    assign bus.alu_out1   = out1_q;
    assign bus.carry0     = c0_q;
    assign bus.carry1     = c1_q;
    assign bus.x          = x_q;
    assign bus.y          = y_q;
    assign bus.mism       = mism_q;
    assign bus.err_cnt    = cnt_q;
    assign bus.err_sticky = sticky_q;
    assign bus.irq        = irq_q;
endmodule

// File: tb/tb_alu_lockstep_n.sv
// Bench for alu_lockstep_n: directed edge cases plus a randomized stream checked against an integer model.
module tb_alu_lockstep_n;
    localparam int W = 4;
    localparam int M = 16;
    localparam int N = 24;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    alu_lockstep_n_if #(.WIDTH(4), .CNT_W(8)) ifa ();
    alu_lockstep_n_if #(.WIDTH(4), .CNT_W(2)) ifs ();

    alu_lockstep_n #(.WIDTH(4), .CNT_W(8)) dut (.wb_clk_i(clk), .wb_rst_n(rst_n), .bus(ifa));
    alu_lockstep_n #(.WIDTH(4), .CNT_W(2)) dut_sat (.wb_clk_i(clk), .wb_rst_n(rst_n), .bus(ifs));

    // Reference ALU in plain integer arithmetic.
    function automatic void ref_alu(input int a, input int b, input int op, output int res, output int cy);
        cy = 0;
        case (op)
            0: begin res = (a + b) % M; cy = (a + b >= M) ? 1 : 0; end
            1: begin res = (a - b + M) % M; cy = (a >= b) ? 1 : 0; end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: res = (M - 1) - (a & b);
            6: res = a;
            default: res = b;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] a0, input logic [3:0] b0, input logic [2:0] s0,
                         input logic [3:0] a1, input logic [3:0] b1, input logic [2:0] s1,
                         input logic lk);
        ifa.in_valid = 1'b1; ifa.lockstep = lk;
        ifa.a0 = a0; ifa.b0 = b0; ifa.sel0 = s0;
        ifa.a1 = a1; ifa.b1 = b1; ifa.sel1 = s1;
    endtask

    task automatic test_reset();
        drive(4'h3, 4'h9, 3'd0, 4'h1, 4'h2, 3'd1, 1'b0);
        rst_n = 1'b0;
        step(); step();
        n_total++; if (ifa.out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", ifa.out_valid); else n_pass++;
        n_total++; if (ifa.alu_out0 !== 4'h0 || ifa.alu_out1 !== 4'h0) $display("FAIL reset_alu_out got=%h/%h exp=0/0", ifa.alu_out0, ifa.alu_out1); else n_pass++;
        n_total++; if ({ifa.x, ifa.y, ifa.mism, ifa.carry0, ifa.carry1} !== 8'h00) $display("FAIL reset_cmp got=%h/%b/%b exp=0", ifa.x, ifa.y, ifa.mism); else n_pass++;
        n_total++; if (ifa.err_cnt !== 8'd0 || ifa.err_sticky !== 1'b0 || ifa.irq !== 1'b0) $display("FAIL reset_err got=%0d/%b/%b exp=0/0/0", ifa.err_cnt, ifa.err_sticky, ifa.irq); else n_pass++;
        ifa.in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        n_total++; if (ifa.out_valid !== 1'b0) $display("FAIL reset_release_valid got=%b exp=0", ifa.out_valid); else n_pass++;
    endtask

    task automatic test_lockstep();
        drive(4'hF, 4'h1, 3'd0, 4'h6, 4'h3, 3'd4, 1'b1);
        step();
        ifa.in_valid = 1'b0;
        step();
        n_total++; if (ifa.out_valid !== 1'b1) $display("FAIL lock_valid got=%b exp=1", ifa.out_valid); else n_pass++;
        n_total++; if (ifa.alu_out0 !== 4'h0 || ifa.alu_out1 !== 4'h0) $display("FAIL lock_out got=%h/%h exp=0/0", ifa.alu_out0, ifa.alu_out1); else n_pass++;
        n_total++; if (ifa.carry0 !== 1'b1 || ifa.carry1 !== 1'b1) $display("FAIL lock_carry got=%b/%b exp=1/1", ifa.carry0, ifa.carry1); else n_pass++;
        n_total++; if (ifa.x !== 4'h0 || ifa.y !== 1'b0 || ifa.mism !== 1'b0) $display("FAIL lock_cmp got=%h/%b/%b exp=0/0/0", ifa.x, ifa.y, ifa.mism); else n_pass++;
        step();
        n_total++; if (ifa.err_cnt !== 8'd0 || ifa.out_valid !== 1'b0) $display("FAIL lock_after got=%0d/%b exp=0/0", ifa.err_cnt, ifa.out_valid); else n_pass++;
    endtask

    task automatic test_independent();
        drive(4'h3, 4'h4, 3'd0, 4'h3, 4'h5, 3'd0, 1'b0);
        step();
        ifa.in_valid = 1'b0;
        step();
        n_total++; if (ifa.alu_out0 !== 4'h7 || ifa.alu_out1 !== 4'h8) $display("FAIL indep_out got=%h/%h exp=7/8", ifa.alu_out0, ifa.alu_out1); else n_pass++;
        n_total++; if (ifa.x !== 4'hF || ifa.y !== 1'b0 || ifa.mism !== 1'b1) $display("FAIL indep_cmp got=%h/%b/%b exp=f/0/1", ifa.x, ifa.y, ifa.mism); else n_pass++;
        step();
        n_total++; if (ifa.err_cnt !== 8'd1 || ifa.err_sticky !== 1'b1 || ifa.irq !== 1'b1) $display("FAIL indep_err got=%0d/%b/%b exp=1/1/1", ifa.err_cnt, ifa.err_sticky, ifa.irq); else n_pass++;
        n_total++; if (ifa.out_valid !== 1'b0 || ifa.x !== 4'h0 || ifa.mism !== 1'b0 || ifa.alu_out0 !== 4'h7) $display("FAIL indep_idle got=%b/%h/%b/%h exp=0/0/0/7", ifa.out_valid, ifa.x, ifa.mism, ifa.alu_out0); else n_pass++;
        step();
        n_total++; if (ifa.irq !== 1'b0 || ifa.err_cnt !== 8'd1) $display("FAIL indep_irq_pulse got=%b/%0d exp=0/1", ifa.irq, ifa.err_cnt); else n_pass++;
    endtask

    task automatic test_arith_edges();
        logic [3:0] ea [3] = '{4'h2, 4'h5, 4'hF};
        logic [3:0] eb [3] = '{4'h5, 4'h2, 4'hF};
        logic [2:0] eo [3] = '{3'd1, 3'd1, 3'd5};
        logic [3:0] er [3] = '{4'hD, 4'h3, 4'h0};
        logic       ec [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            if (i < 3) drive(ea[i], eb[i], eo[i], 4'h0, 4'h0, 3'd0, 1'b1);
            else ifa.in_valid = 1'b0;
            step();
            if (i >= 1) begin
                n_total++;
                if (ifa.alu_out0 !== er[i-1] || ifa.carry0 !== ec[i-1] || ifa.alu_out1 !== er[i-1] || ifa.out_valid !== 1'b1)
                    $display("FAIL arith_edge%0d got=%h c=%b v=%b exp=%h c=%b", i-1, ifa.alu_out0, ifa.carry0, ifa.out_valid, er[i-1], ec[i-1]);
                else n_pass++;
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        int ra0 [N], rb0 [N], rs0 [N], ra1 [N], rb1 [N], rs1 [N], rl [N];
        int eo0 [N], ec0 [N], eo1 [N], ec1 [N], em [N];
        int exp_cnt, exp_st, exp_irq, t, ea1, eb1, es1;
        ifa.clr_i = 1'b1;
        step();
        ifa.clr_i = 1'b0;
        n_total++; if (ifa.err_cnt !== 8'd0 || ifa.err_sticky !== 1'b0) $display("FAIL clear_plain got=%0d/%b exp=0/0", ifa.err_cnt, ifa.err_sticky); else n_pass++;
        for (int k = 0; k < N; k++) begin
            ra0[k] = $urandom_range(M-1); rb0[k] = $urandom_range(M-1); rs0[k] = $urandom_range(7);
            ra1[k] = $urandom_range(M-1); rb1[k] = $urandom_range(M-1); rs1[k] = $urandom_range(7);
            rl[k]  = $urandom_range(1);
            ea1 = rl[k] ? ra0[k] : ra1[k];
            eb1 = rl[k] ? rb0[k] : rb1[k];
            es1 = rl[k] ? rs0[k] : rs1[k];
            ref_alu(ra0[k], rb0[k], rs0[k], eo0[k], ec0[k]);
            ref_alu(ea1, eb1, es1, eo1[k], ec1[k]);
            em[k] = (eo0[k] != eo1[k] || ec0[k] != ec1[k]) ? 1 : 0;
        end
        exp_cnt = 0; exp_st = 0;
        for (int i = 0; i <= N + 1; i++) begin
            if (i < N) drive(4'(ra0[i]), 4'(rb0[i]), 3'(rs0[i]), 4'(ra1[i]), 4'(rb1[i]), 3'(rs1[i]), rl[i][0]);
            else ifa.in_valid = 1'b0;
            step();
            exp_irq = 0;
            if (i >= 2 && em[i-2] == 1) begin
                exp_irq = exp_st ? 0 : 1;
                exp_st = 1;
                if (exp_cnt < 255) exp_cnt++;
            end
            if (i >= 1 && i <= N) begin
                t = i - 1;
                n_total++;
                if (ifa.out_valid !== 1'b1 || ifa.alu_out0 !== 4'(eo0[t]) || ifa.carry0 !== ec0[t][0] || ifa.alu_out1 !== 4'(eo1[t]) || ifa.carry1 !== ec1[t][0])
                    $display("FAIL stream_res%0d got=v%b %h/%b %h/%b exp=v1 %h/%0d %h/%0d", t, ifa.out_valid, ifa.alu_out0, ifa.carry0, ifa.alu_out1, ifa.carry1, eo0[t], ec0[t], eo1[t], ec1[t]);
                else n_pass++;
                n_total++;
                if (ifa.x !== 4'(eo0[t] ^ eo1[t]) || ifa.y !== 1'(ec0[t] ^ ec1[t]) || ifa.mism !== em[t][0])
                    $display("FAIL stream_cmp%0d got=%h/%b/%b exp=%h/%0d/%0d", t, ifa.x, ifa.y, ifa.mism, eo0[t] ^ eo1[t], ec0[t] ^ ec1[t], em[t]);
                else n_pass++;
            end
            n_total++;
            if (ifa.err_cnt !== 8'(exp_cnt) || ifa.err_sticky !== exp_st[0] || ifa.irq !== exp_irq[0])
                $display("FAIL stream_err%0d got=%0d/%b/%b exp=%0d/%0d/%0d", i, ifa.err_cnt, ifa.err_sticky, ifa.irq, exp_cnt, exp_st, exp_irq);
            else n_pass++;
        end
        step();
        n_total++;
        if (ifa.out_valid !== 1'b0 || ifa.x !== 4'h0 || ifa.y !== 1'b0 || ifa.mism !== 1'b0 || ifa.alu_out0 !== 4'(eo0[N-1]) || ifa.alu_out1 !== 4'(eo1[N-1]))
            $display("FAIL hold_idle got=v%b x%h m%b %h/%h exp=v0 x0 m0 %h/%h", ifa.out_valid, ifa.x, ifa.mism, ifa.alu_out0, ifa.alu_out1, eo0[N-1], eo1[N-1]);
        else n_pass++;
    endtask

    task automatic test_clear();
        drive(4'h1, 4'h1, 3'd0, 4'h1, 4'h2, 3'd0, 1'b0);
        step();
        ifa.in_valid = 1'b0;
        step();
        n_total++; if (ifa.mism !== 1'b1) $display("FAIL clr_setup_mism got=%b exp=1", ifa.mism); else n_pass++;
        ifa.clr_i = 1'b1;
        step();
        n_total++; if (ifa.err_cnt !== 8'd1 || ifa.err_sticky !== 1'b1 || ifa.irq !== 1'b1) $display("FAIL clr_collision got=%0d/%b/%b exp=1/1/1", ifa.err_cnt, ifa.err_sticky, ifa.irq); else n_pass++;
        step();
        ifa.clr_i = 1'b0;
        n_total++; if (ifa.err_cnt !== 8'd0 || ifa.err_sticky !== 1'b0 || ifa.irq !== 1'b0) $display("FAIL clr_only got=%0d/%b/%b exp=0/0/0", ifa.err_cnt, ifa.err_sticky, ifa.irq); else n_pass++;
    endtask

    task automatic test_saturation();
        int irqs = 0;
        int exp_c;
        for (int i = 0; i <= 6; i++) begin
            if (i < 5) begin
                ifs.in_valid = 1'b1; ifs.lockstep = 1'b0;
                ifs.a0 = 4'($urandom_range(M-1)); ifs.b0 = 4'h0; ifs.sel0 = 3'd6;
                ifs.a1 = ifs.a0 ^ 4'h8; ifs.b1 = 4'h0; ifs.sel1 = 3'd6;
            end else ifs.in_valid = 1'b0;
            step();
            if (i >= 2) begin
                exp_c = (i - 1 > 3) ? 3 : i - 1;
                if (ifs.irq === 1'b1) irqs++;
                n_total++;
                if (ifs.err_cnt !== 2'(exp_c) || ifs.err_sticky !== 1'b1)
                    $display("FAIL sat_cnt%0d got=%0d/%b exp=%0d/1", i - 2, ifs.err_cnt, ifs.err_sticky, exp_c);
                else n_pass++;
            end
        end
        n_total++; if (irqs != 1) $display("FAIL sat_irq_count got=%0d exp=1", irqs); else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive(4'h3, 4'h4, 3'd0, 4'h3, 4'h5, 3'd0, 1'b0);
        step();
        ifa.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        n_total++; if (ifa.out_valid !== 1'b0 || ifa.alu_out0 !== 4'h0 || ifa.alu_out1 !== 4'h0 || ifa.err_cnt !== 8'd0 || ifa.err_sticky !== 1'b0) $display("FAIL rstmid_state got=v%b %h/%h %0d/%b exp=0", ifa.out_valid, ifa.alu_out0, ifa.alu_out1, ifa.err_cnt, ifa.err_sticky); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            step();
            n_total++;
            if (ifa.out_valid !== 1'b0 || ifa.mism !== 1'b0 || ifa.irq !== 1'b0 || ifa.err_cnt !== 8'd0)
                $display("FAIL rstmid_drop%0d got=v%b m%b i%b c%0d exp=0", i, ifa.out_valid, ifa.mism, ifa.irq, ifa.err_cnt);
            else n_pass++;
        end
    endtask

`ifdef ALU_LOCKSTEP_INJECT_EN
    task automatic test_inject();
        drive(4'h3, 4'h2, 3'd0, 4'h0, 4'h0, 3'd0, 1'b1);
        ifa.inj_en = 1'b1; ifa.inj_mask = 4'h4;
        step();
        ifa.in_valid = 1'b0; ifa.inj_en = 1'b0; ifa.inj_mask = 4'h0;
        step();
        n_total++; if (ifa.x !== 4'h4 || ifa.y !== 1'b0 || ifa.mism !== 1'b1) $display("FAIL inj_cmp got=%h/%b/%b exp=4/0/1", ifa.x, ifa.y, ifa.mism); else n_pass++;
        n_total++; if (ifa.alu_out0 !== 4'h5 || ifa.alu_out1 !== 4'h1) $display("FAIL inj_out got=%h/%h exp=5/1", ifa.alu_out0, ifa.alu_out1); else n_pass++;
        step();
        n_total++; if (ifa.err_cnt !== 8'd1 || ifa.err_sticky !== 1'b1) $display("FAIL inj_err got=%0d/%b exp=1/1", ifa.err_cnt, ifa.err_sticky); else n_pass++;
    endtask
`endif

    initial begin
        ifa.in_valid = 1'b0; ifa.lockstep = 1'b0; ifa.clr_i = 1'b0;
        ifa.a0 = '0; ifa.b0 = '0; ifa.a1 = '0; ifa.b1 = '0; ifa.sel0 = '0; ifa.sel1 = '0;
        ifs.in_valid = 1'b0; ifs.lockstep = 1'b0; ifs.clr_i = 1'b0;
        ifs.a0 = '0; ifs.b0 = '0; ifs.a1 = '0; ifs.b1 = '0; ifs.sel0 = '0; ifs.sel1 = '0;
`ifdef ALU_LOCKSTEP_INJECT_EN
        ifa.inj_en = 1'b0; ifa.inj_mask = '0;
        ifs.inj_en = 1'b0; ifs.inj_mask = '0;
`endif
        test_reset();
        test_lockstep();
        test_independent();
        test_arith_edges();
        test_back_to_back();
        test_clear();
        test_saturation();
        test_reset_mid();
`ifdef ALU_LOCKSTEP_INJECT_EN
        test_inject();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
